// File: rtl/bp_cce_mshr_file.sv
// Multi-entry MSHR and GPR file for the CCE: block conflict check, lowest-free allocation, field writes, restore, free.
// Define BP_CCE_MSHR_STATS_EN to build the occupancy / high-water-mark counters (outputs tied to zero otherwise).
module bp_cce_mshr_file
    #(parameter int num_mshr_p             = 4
    , parameter int paddr_width_p          = 56
    , parameter int num_lce_p              = 8
    , parameter int lce_assoc_p            = 8
    , parameter int block_size_in_bytes_p  = 64
    , parameter int num_flags_p            = 16
    , parameter int num_gpr_p              = 8
    , parameter int gpr_width_p            = 16
    , localparam int lg_mshr_lp            = (num_mshr_p  > 1) ? $clog2(num_mshr_p)  : 1
    , localparam int lg_lce_lp             = (num_lce_p   > 1) ? $clog2(num_lce_p)   : 1
    , localparam int lg_assoc_lp           = (lce_assoc_p > 1) ? $clog2(lce_assoc_p) : 1
    , localparam int lg_block_lp           = $clog2(block_size_in_bytes_p)
    , localparam int entry_width_lp        = paddr_width_p + lg_lce_lp + lg_assoc_lp + num_flags_p + 3
    )
    (input  logic                              clk_i
    , input  logic                             reset_i
    , input  logic                             alloc_v_i
    , input  logic [paddr_width_p-1:0]         alloc_paddr_i
    , input  logic [lg_lce_lp-1:0]             alloc_lce_id_i
    , input  logic [lg_assoc_lp-1:0]           alloc_way_i
    , output logic                             alloc_ready_o
    , output logic                             alloc_conflict_o
    , output logic [lg_mshr_lp-1:0]            alloc_id_o
    , input  logic [lg_mshr_lp-1:0]            sel_id_i
    , input  logic [num_flags_p-1:0]           flag_w_mask_i
    , input  logic [num_flags_p-1:0]           flags_i
    , input  logic                             coh_w_v_i
    , input  logic [2:0]                       coh_i
    , input  logic                             free_v_i
    , input  logic [lg_mshr_lp-1:0]            free_id_i
    , input  logic                             restore_v_i
    , input  logic [lg_mshr_lp-1:0]            restore_id_i
    , input  logic [entry_width_lp-1:0]        restore_payload_i
    , input  logic [num_gpr_p-1:0]             gpr_w_mask_i
    , input  logic [gpr_width_p-1:0]           gpr_data_i
    , output logic [entry_width_lp-1:0]        mshr_o
    , output logic [num_mshr_p-1:0]            valid_o
    , output logic [num_gpr_p*gpr_width_p-1:0] gpr_o
    , output logic                             err_o
    , output logic [lg_mshr_lp:0]              occupancy_o
    , output logic [lg_mshr_lp:0]              hwm_o
    );

    logic [num_mshr_p-1:0]    valid_r;
    logic [paddr_width_p-1:0] paddr_r [num_mshr_p];
    logic [lg_lce_lp-1:0]     lce_r   [num_mshr_p];
    logic [lg_assoc_lp-1:0]   way_r   [num_mshr_p];
    logic [num_flags_p-1:0]   flags_r [num_mshr_p];
    logic [2:0]               coh_r   [num_mshr_p];
    logic                     err_r;
    logic [gpr_width_p-1:0]   gpr_r   [num_gpr_p];

    logic [num_mshr_p-1:0]            restore_oh_s, free_oh_s, sel_oh_s, cand_s, alloc_oh_s;
    logic [lg_mshr_lp-1:0]            alloc_id_s;
    logic                             conflict_s, ready_s, field_v_s, err_set_s;
    logic [entry_width_lp-1:0]        mshr_s;
    logic [num_gpr_p*gpr_width_p-1:0] gpr_s;

    function automatic logic [num_mshr_p-1:0] id_to_oh(input logic [lg_mshr_lp-1:0] id);
        logic [num_mshr_p-1:0] oh;
        for (int i = 0; i < num_mshr_p; i++) begin
            oh[i] = (id == lg_mshr_lp'(i));
        end
        return oh;
    endfunction

    // Descending scan so the lowest set bit is the last one written
    function automatic logic [lg_mshr_lp-1:0] lowest_idx(input logic [num_mshr_p-1:0] v);
        logic [lg_mshr_lp-1:0] idx;
        idx = '0;
        for (int i = num_mshr_p - 1; i >= 0; i--) begin
            idx = v[i] ? lg_mshr_lp'(i) : idx;
        end
        return idx;
    endfunction

    // Allocation candidates, block conflict detection and protocol error decode
    always_comb begin
        restore_oh_s = id_to_oh(restore_id_i) & {num_mshr_p{restore_v_i}};
        free_oh_s    = id_to_oh(free_id_i) & {num_mshr_p{free_v_i}};
        sel_oh_s     = id_to_oh(sel_id_i);
        cand_s       = ~valid_r & ~restore_oh_s;
        alloc_id_s   = lowest_idx(cand_s);
        conflict_s   = 1'b0;
        for (int i = 0; i < num_mshr_p; i++) begin
            conflict_s = conflict_s | (valid_r[i] &
                (paddr_r[i][paddr_width_p-1:lg_block_lp] == alloc_paddr_i[paddr_width_p-1:lg_block_lp]));
        end
        conflict_s   = conflict_s & alloc_v_i;
        ready_s      = (|cand_s) & ~conflict_s;
        alloc_oh_s   = id_to_oh(alloc_id_s) & {num_mshr_p{alloc_v_i & ready_s}};
        field_v_s    = (|flag_w_mask_i) | coh_w_v_i;
        err_set_s    = (free_v_i & ~(|(free_oh_s & valid_r)))
                     | (restore_v_i & (|(restore_oh_s & valid_r)))
                     | (field_v_s & ~(|(sel_oh_s & valid_r)));
    end

    // Entry state: a restore owns its entry even when illegal; alloc only lands on invalid entries
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            valid_r <= '0;
            for (int i = 0; i < num_mshr_p; i++) begin
                paddr_r[i] <= '0;
                lce_r[i]   <= '0;
                way_r[i]   <= '0;
                flags_r[i] <= '0;
                coh_r[i]   <= 3'b000;
            end
        end else begin
            for (int i = 0; i < num_mshr_p; i++) begin
                if (restore_oh_s[i]) begin
                    if (!valid_r[i]) begin
                        {flags_r[i], coh_r[i], way_r[i], lce_r[i], paddr_r[i]} <= restore_payload_i;
                        valid_r[i] <= 1'b1;
                    end
                end else if (alloc_oh_s[i]) begin
                    paddr_r[i] <= alloc_paddr_i;
                    lce_r[i]   <= alloc_lce_id_i;
                    way_r[i]   <= alloc_way_i;
                    flags_r[i] <= '0;
                    coh_r[i]   <= 3'b000;
                    valid_r[i] <= 1'b1;
                end else if (free_oh_s[i] & valid_r[i]) begin
                    valid_r[i] <= 1'b0;
                end else if (field_v_s & sel_oh_s[i] & valid_r[i]) begin
                    flags_r[i] <= (flags_r[i] & ~flag_w_mask_i) | (flags_i & flag_w_mask_i);
                    if (coh_w_v_i) begin
                        coh_r[i] <= coh_i;
                    end
                end
            end
        end
    end

    // Sticky protocol error flag
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_r | err_set_s;
        end
    end

    // GPRs hold their value unless masked in
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int g = 0; g < num_gpr_p; g++) begin
                gpr_r[g] <= '0;
            end
        end else begin
            for (int g = 0; g < num_gpr_p; g++) begin
                if (gpr_w_mask_i[g]) begin
                    gpr_r[g] <= gpr_data_i;
                end
            end
        end
    end

    // Selected-entry mux and GPR flattening
    always_comb begin
        mshr_s = '0;
        gpr_s  = '0;
        for (int i = 0; i < num_mshr_p; i++) begin
            mshr_s = mshr_s | ({entry_width_lp{sel_oh_s[i]}} &
                              {flags_r[i], coh_r[i], way_r[i], lce_r[i], paddr_r[i]});
        end
        for (int g = 0; g < num_gpr_p; g++) begin
            gpr_s[g*gpr_width_p +: gpr_width_p] = gpr_r[g];
        end
    end

    assign alloc_ready_o    = ready_s;
    assign alloc_conflict_o = conflict_s;
    assign alloc_id_o       = alloc_id_s;
    assign mshr_o           = mshr_s;
    assign valid_o          = valid_r;
    assign gpr_o            = gpr_s;
    assign err_o            = err_r;

`ifdef BP_CCE_MSHR_STATS_EN
    function automatic logic [lg_mshr_lp:0] popcount(input logic [num_mshr_p-1:0] v);
        logic [lg_mshr_lp:0] cnt;
        cnt = '0;
        for (int i = 0; i < num_mshr_p; i++) begin
            cnt = cnt + {{lg_mshr_lp{1'b0}}, v[i]};
        end
        return cnt;
    endfunction

    logic [lg_mshr_lp:0] occ_s;
    logic [lg_mshr_lp:0] hwm_r;

    assign occ_s = popcount(valid_r);

    // High-water mark trails occupancy by one cycle
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            hwm_r <= '0;
        end else if (occ_s > hwm_r) begin
            hwm_r <= occ_s;
        end
    end

    assign occupancy_o = occ_s;
    assign hwm_o       = hwm_r;
`else
    assign occupancy_o = '0;
    assign hwm_o       = '0;
`endif

endmodule

// File: tb/tb_bp_cce_mshr_file.sv
// Self-checking bench for bp_cce_mshr_file: directed vector table, multi-cycle sequences, random vs. reference model.
module tb_bp_cce_mshr_file;
    localparam int EW = 81;
`ifdef BP_CCE_MSHR_STATS_EN
    localparam bit stats_en = 1'b1;
`else
    localparam bit stats_en = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          reset_i = 1'b1;
    logic          alloc_v_i;
    logic [55:0]   alloc_paddr_i;
    logic [2:0]    alloc_lce_id_i, alloc_way_i;
    logic          alloc_ready_o, alloc_conflict_o;
    logic [1:0]    alloc_id_o, sel_id_i, free_id_i, restore_id_i;
    logic [15:0]   flag_w_mask_i, flags_i, gpr_data_i;
    logic          coh_w_v_i, free_v_i, restore_v_i, err_o;
    logic [2:0]    coh_i, occupancy_o, hwm_o;
    logic [EW-1:0] restore_payload_i, mshr_o;
    logic [7:0]    gpr_w_mask_i;
    logic [3:0]    valid_o;
    logic [127:0]  gpr_o;

    always #5 clk_i = ~clk_i;

    bp_cce_mshr_file dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .alloc_v_i(alloc_v_i), .alloc_paddr_i(alloc_paddr_i), .alloc_lce_id_i(alloc_lce_id_i),
        .alloc_way_i(alloc_way_i), .alloc_ready_o(alloc_ready_o), .alloc_conflict_o(alloc_conflict_o),
        .alloc_id_o(alloc_id_o), .sel_id_i(sel_id_i), .flag_w_mask_i(flag_w_mask_i), .flags_i(flags_i),
        .coh_w_v_i(coh_w_v_i), .coh_i(coh_i), .free_v_i(free_v_i), .free_id_i(free_id_i),
        .restore_v_i(restore_v_i), .restore_id_i(restore_id_i), .restore_payload_i(restore_payload_i),
        .gpr_w_mask_i(gpr_w_mask_i), .gpr_data_i(gpr_data_i), .mshr_o(mshr_o), .valid_o(valid_o),
        .gpr_o(gpr_o), .err_o(err_o), .occupancy_o(occupancy_o), .hwm_o(hwm_o)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Entry record layout: {flags, next_coh, way, lce, paddr}
    function automatic logic [EW-1:0] mk(input logic [15:0] f, input logic [2:0] c, input logic [2:0] w,
                                         input logic [2:0] l, input logic [55:0] a);
        return {f, c, w, l, a};
    endfunction

    typedef struct {
        logic          alloc_v;
        logic [55:0]   paddr;
        logic [2:0]    lce, way;
        logic [1:0]    sel;
        logic [15:0]   fmask, flags;
        logic          coh_w;
        logic [2:0]    coh;
        logic          free_v;
        logic [1:0]    free_id;
        logic          restore_v;
        logic [1:0]    restore_id;
        logic          e_ready, e_conf, chk_id;
        logic [1:0]    e_id;
        logic [3:0]    e_valid;
        logic          e_err, chk_mshr;
        logic [EW-1:0] e_mshr;
    } vec_t;

    vec_t          tbl [14];
    logic [EW-1:0] pay_p, ent0, ent1, ent2;

    function automatic vec_t row(input logic [1:0] sel, input logic rdy, input logic conf, input logic chk_id,
                                 input logic [1:0] id, input logic [3:0] vld, input logic err,
                                 input logic chk_m, input logic [EW-1:0] m);
        vec_t v;
        v.alloc_v = 1'b0; v.paddr = 56'h0; v.lce = 3'd0; v.way = 3'd0; v.sel = sel;
        v.fmask = 16'h0; v.flags = 16'h0; v.coh_w = 1'b0; v.coh = 3'd0;
        v.free_v = 1'b0; v.free_id = 2'd0; v.restore_v = 1'b0; v.restore_id = 2'd0;
        v.e_ready = rdy; v.e_conf = conf; v.chk_id = chk_id; v.e_id = id;
        v.e_valid = vld; v.e_err = err; v.chk_mshr = chk_m; v.e_mshr = m;
        return v;
    endfunction

    function automatic vec_t w_alloc(input vec_t v, input logic [55:0] a, input logic [2:0] l, input logic [2:0] w);
        v.alloc_v = 1'b1; v.paddr = a; v.lce = l; v.way = w;
        return v;
    endfunction

    function automatic vec_t w_free(input vec_t v, input logic [1:0] id);
        v.free_v = 1'b1; v.free_id = id;
        return v;
    endfunction

    function automatic vec_t w_field(input vec_t v, input logic [15:0] m, input logic [15:0] f,
                                     input logic cw, input logic [2:0] c);
        v.fmask = m; v.flags = f; v.coh_w = cw; v.coh = c;
        return v;
    endfunction

    task automatic drive_idle();
        alloc_v_i = 1'b0; alloc_paddr_i = 56'h0; alloc_lce_id_i = 3'd0; alloc_way_i = 3'd0;
        sel_id_i = 2'd0; flag_w_mask_i = 16'h0; flags_i = 16'h0; coh_w_v_i = 1'b0; coh_i = 3'd0;
        free_v_i = 1'b0; free_id_i = 2'd0; restore_v_i = 1'b0; restore_id_i = 2'd0;
        restore_payload_i = '0; gpr_w_mask_i = 8'h0; gpr_data_i = 16'h0;
    endtask

    task automatic enables_off();
        alloc_v_i = 1'b0; flag_w_mask_i = 16'h0; coh_w_v_i = 1'b0;
        free_v_i = 1'b0; restore_v_i = 1'b0; gpr_w_mask_i = 8'h0;
    endtask

    // Reference model state
    logic [EW-1:0] m_ent [4];
    logic [3:0]    m_valid;
    logic          m_err;
    logic [15:0]   m_gpr [8];
    int            m_hwm;

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_ent[i] = '0;
        for (int g = 0; g < 8; g++) m_gpr[g] = 16'h0;
        m_valid = 4'h0; m_err = 1'b0; m_hwm = 0;
    endtask

    task automatic do_reset();
        drive_idle();
        reset_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
        @(posedge clk_i);
        #1;
        model_clear();
    endtask

    task automatic apply_row(input vec_t v, input int k);
        alloc_v_i = v.alloc_v; alloc_paddr_i = v.paddr; alloc_lce_id_i = v.lce; alloc_way_i = v.way;
        sel_id_i = v.sel; flag_w_mask_i = v.fmask; flags_i = v.flags; coh_w_v_i = v.coh_w; coh_i = v.coh;
        free_v_i = v.free_v; free_id_i = v.free_id; restore_v_i = v.restore_v; restore_id_i = v.restore_id;
        restore_payload_i = pay_p;
        @(negedge clk_i);
        check($sformatf("row%0d_ready", k), alloc_ready_o, v.e_ready);
        check($sformatf("row%0d_conflict", k), alloc_conflict_o, v.e_conf);
        if (v.chk_id) check($sformatf("row%0d_alloc_id", k), alloc_id_o, v.e_id);
        @(posedge clk_i);
        #1;
        enables_off();
        check($sformatf("row%0d_valid", k), valid_o, v.e_valid);
        check($sformatf("row%0d_err", k), err_o, v.e_err);
        if (v.chk_mshr) check($sformatf("row%0d_mshr", k), mshr_o, v.e_mshr);
    endtask

    task automatic run_random(input int cycles);
        logic       e_conf, e_ready, any_cand, fieldw;
        logic [1:0] e_id;
        logic [3:0] v0;
        logic [127:0] e_gpr;
        int occ0;
        for (int c = 0; c < cycles; c++) begin
            alloc_v_i      = ($urandom_range(0, 1) == 1);
            alloc_paddr_i  = 56'h10000 + (56'($urandom_range(0, 7)) << 6) + 56'($urandom_range(0, 63));
            alloc_lce_id_i = 3'($urandom_range(0, 7));
            alloc_way_i    = 3'($urandom_range(0, 7));
            sel_id_i       = 2'($urandom_range(0, 3));
            flags_i        = 16'($urandom());
            coh_i          = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) begin
                flag_w_mask_i = 16'($urandom());
                coh_w_v_i     = ($urandom_range(0, 1) == 1);
            end else begin
                flag_w_mask_i = 16'h0;
                coh_w_v_i     = 1'b0;
            end
            free_v_i          = ($urandom_range(0, 3) == 0);
            free_id_i         = 2'($urandom_range(0, 3));
            restore_v_i       = ($urandom_range(0, 7) == 0);
            restore_id_i      = 2'($urandom_range(0, 3));
            restore_payload_i = EW'({$urandom(), $urandom(), $urandom()});
            gpr_w_mask_i      = ($urandom_range(0, 3) == 0) ? 8'($urandom()) : 8'h00;
            gpr_data_i        = 16'($urandom());
            @(negedge clk_i);
            e_conf = 1'b0;
            for (int i = 0; i < 4; i++)
                if (m_valid[i] && m_ent[i][55:6] == alloc_paddr_i[55:6]) e_conf = alloc_v_i;
            any_cand = 1'b0;
            e_id = 2'd0;
            for (int i = 3; i >= 0; i--)
                if (!m_valid[i] && !(restore_v_i && restore_id_i == 2'(i))) begin
                    any_cand = 1'b1;
                    e_id = 2'(i);
                end
            e_ready = any_cand && !e_conf;
            for (int g = 0; g < 8; g++) e_gpr[g*16 +: 16] = m_gpr[g];
            occ0 = $countones(m_valid);
            check("rnd_conflict", alloc_conflict_o, e_conf);
            check("rnd_ready", alloc_ready_o, e_ready);
            if (any_cand) check("rnd_alloc_id", alloc_id_o, e_id);
            check("rnd_valid", valid_o, m_valid);
            check("rnd_mshr", mshr_o, m_ent[sel_id_i]);
            check("rnd_err", err_o, m_err);
            check("rnd_gpr", gpr_o, e_gpr);
            check("rnd_occ", occupancy_o, stats_en ? occ0 : 0);
            check("rnd_hwm", hwm_o, stats_en ? m_hwm : 0);
            // next state from the rules, using the pre-edge valid set
            v0 = m_valid;
            fieldw = (flag_w_mask_i != 16'h0) || coh_w_v_i;
            if (free_v_i && !v0[free_id_i]) m_err = 1'b1;
            if (restore_v_i && v0[restore_id_i]) m_err = 1'b1;
            if (fieldw && !v0[sel_id_i]) m_err = 1'b1;
            if (alloc_v_i && e_ready) begin
                m_ent[e_id]   = mk(16'h0, 3'd0, alloc_way_i, alloc_lce_id_i, alloc_paddr_i);
                m_valid[e_id] = 1'b1;
            end
            if (restore_v_i && !v0[restore_id_i]) begin
                m_ent[restore_id_i]   = restore_payload_i;
                m_valid[restore_id_i] = 1'b1;
            end
            if (free_v_i && v0[free_id_i] && !(restore_v_i && restore_id_i == free_id_i))
                m_valid[free_id_i] = 1'b0;
            if (fieldw && v0[sel_id_i] && !(restore_v_i && restore_id_i == sel_id_i)
                       && !(free_v_i && free_id_i == sel_id_i)) begin
                m_ent[sel_id_i][80:65] = (m_ent[sel_id_i][80:65] & ~flag_w_mask_i) | (flags_i & flag_w_mask_i);
                if (coh_w_v_i) m_ent[sel_id_i][64:62] = coh_i;
            end
            for (int g = 0; g < 8; g++) if (gpr_w_mask_i[g]) m_gpr[g] = gpr_data_i;
            if (occ0 > m_hwm) m_hwm = occ0;
            @(posedge clk_i);
            #1;
        end
    endtask

    initial begin
        pay_p = mk(16'h1234, 3'd6, 3'd1, 3'd5, 56'h8040);
        ent0  = mk(16'h0000, 3'd0, 3'd3, 3'd2, 56'h1000);
        ent1  = mk(16'h0005, 3'd0, 3'd4, 3'd1, 56'h2000);
        ent2  = mk(16'hA000, 3'd5, 3'd2, 3'd3, 56'h5000);
        //                 sel  rdy   conf  chkid id    valid    err   chkm  mshr
        tbl[0]  = w_alloc(row(2'd0, 1'b1, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b0, 1'b1, ent0), 56'h1000, 3'd2, 3'd3);
        tbl[1]  = w_alloc(row(2'd0, 1'b0, 1'b1, 1'b1, 2'd1, 4'b0001, 1'b0, 1'b1, ent0), 56'h1020, 3'd1, 3'd1);
        tbl[2]  = w_alloc(row(2'd0, 1'b1, 1'b0, 1'b1, 2'd1, 4'b0011, 1'b0, 1'b1, ent0), 56'h2000, 3'd1, 3'd4);
        tbl[3]  = w_alloc(row(2'd0, 1'b1, 1'b0, 1'b1, 2'd2, 4'b0111, 1'b0, 1'b1, ent0), 56'h3000, 3'd5, 3'd6);
        tbl[4]  = w_alloc(row(2'd0, 1'b1, 1'b0, 1'b1, 2'd3, 4'b1111, 1'b0, 1'b1, ent0), 56'h4000, 3'd7, 3'd0);
        tbl[5]  = w_alloc(row(2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b1111, 1'b0, 1'b1, ent0), 56'h5000, 3'd3, 3'd2);
        tbl[6]  = w_free(w_alloc(row(2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b1011, 1'b0, 1'b1, ent0),
                                 56'h5000, 3'd3, 3'd2), 2'd2);
        tbl[7]  = w_alloc(row(2'd0, 1'b1, 1'b0, 1'b1, 2'd2, 4'b1111, 1'b0, 1'b1, ent0), 56'h5000, 3'd3, 3'd2);
        tbl[8]  = w_field(row(2'd1, 1'b0, 1'b0, 1'b0, 2'd0, 4'b1111, 1'b0, 1'b1, ent1), 16'h0005, 16'hFFFF, 1'b0, 3'd0);
        tbl[9]  = w_free(row(2'd1, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0111, 1'b0, 1'b1, ent1), 2'd3);
        tbl[10] = w_field(row(2'd3, 1'b1, 1'b0, 1'b1, 2'd3, 4'b0111, 1'b1, 1'b0, ent1), 16'h0001, 16'hFFFF, 1'b0, 3'd0);
        tbl[11] = w_free(row(2'd1, 1'b1, 1'b0, 1'b1, 2'd3, 4'b0110, 1'b1, 1'b1, ent1), 2'd0);
        tbl[12] = w_alloc(row(2'd0, 1'b1, 1'b0, 1'b1, 2'd3, 4'b1111, 1'b1, 1'b1, pay_p), 56'h6000, 3'd0, 3'd5);
        tbl[12].restore_v = 1'b1;
        tbl[12].restore_id = 2'd0;
        tbl[13] = w_field(row(2'd2, 1'b0, 1'b0, 1'b0, 2'd0, 4'b1111, 1'b1, 1'b1, ent2), 16'hF000, 16'hA5A5, 1'b1, 3'd5);

        do_reset();
        check("rst_valid", valid_o, 4'h0);
        check("rst_err", err_o, 1'b0);
        check("rst_gpr", gpr_o, 128'h0);
        check("rst_mshr", mshr_o, '0);
        check("rst_ready", alloc_ready_o, 1'b1);
        check("rst_alloc_id", alloc_id_o, 2'd0);
        check("rst_occ", occupancy_o, 3'd0);
        check("rst_hwm", hwm_o, 3'd0);

        for (int k = 0; k < 14; k++) apply_row(tbl[k], k);

        // restore and alloc in the same cycle, with statistics
        do_reset();
        alloc_v_i = 1'b1; alloc_paddr_i = 56'h9000;
        @(posedge clk_i);
        #1;
        alloc_v_i = 1'b0;
        check("st_occ1", occupancy_o, stats_en ? 3'd1 : 3'd0);
        check("st_hwm0", hwm_o, 3'd0);
        restore_v_i = 1'b1; restore_id_i = 2'd1; restore_payload_i = pay_p;
        alloc_v_i = 1'b1; alloc_paddr_i = 56'hA000;
        #1;
        check("st_alloc_id", alloc_id_o, 2'd2);
        check("st_ready", alloc_ready_o, 1'b1);
        @(posedge clk_i);
        #1;
        enables_off();
        sel_id_i = 2'd1;
        #1;
        check("st_valid", valid_o, 4'b0111);
        check("st_restored", mshr_o, pay_p);
        check("st_occ3", occupancy_o, stats_en ? 3'd3 : 3'd0);
        check("st_hwm1", hwm_o, stats_en ? 3'd1 : 3'd0);
        @(posedge clk_i);
        #1;
        check("st_hwm3", hwm_o, stats_en ? 3'd3 : 3'd0);

        do_reset();
        run_random(400);

        // asynchronous reset while an allocation is being requested
        do_reset();
        alloc_v_i = 1'b1; alloc_paddr_i = 56'h7000;
        gpr_w_mask_i = 8'hFF; gpr_data_i = 16'h1234;
        free_v_i = 1'b1; free_id_i = 2'd3;
        @(posedge clk_i);
        #1;
        alloc_paddr_i = 56'h8000; gpr_w_mask_i = 8'h00; free_v_i = 1'b0;
        check("ar_pre_valid", valid_o, 4'b0001);
        check("ar_pre_err", err_o, 1'b1);
        check("ar_pre_gpr", gpr_o, {8{16'h1234}});
        #2;
        reset_i = 1'b1;
        #1;
        check("ar_valid", valid_o, 4'h0);
        check("ar_gpr", gpr_o, 128'h0);
        check("ar_err", err_o, 1'b0);
        @(negedge clk_i);
        reset_i = 1'b0;
        drive_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
